// File: rtl/imm_encoder.sv
// Immediate packer and range checker feeding a 2-entry valid/ready FIFO.
// Optional error counter built only when IMM_ENC_ERRCNT_EN is defined.
module imm_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       InmSrc,
  input  logic [18:0]      Imm,
  input  logic [11:0]      Hdr,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [27:0]      Instr,
  output logic             OutErr,
  input  logic             ErrClr,
  output logic [CNT_W-1:0] ErrCount
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  function automatic logic [27:0] f_pack(input logic [1:0] fmt,
                                         input logic [11:0] hdr,
                                         input logic [18:0] imm);
    logic [27:0] res;
    case (fmt)
      2'b10:   res = {hdr[11:1], imm[16:0]};
      2'b11:   res = {hdr[11:0], imm[15:0]};
      default: res = {hdr[11:3], imm[18:0]};
    endcase
    return res;
  endfunction

  function automatic logic f_range_err(input logic [1:0] fmt,
                                       input logic [18:0] imm);
    logic res;
    case (fmt)
      2'b10:   res = |imm[18:17];
      2'b11:   res = |imm[18:16];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic [28:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_err;
  logic [28:0] w_word;

  // Handshake decisions depend only on the registered occupancy.
  assign InReady  = (r_count != FULL);
  assign OutValid = (r_count != 2'd0);
  assign w_push   = InValid && InReady;
  assign w_pop    = OutValid && OutReady;

  assign w_err  = f_range_err(InmSrc, Imm);
  assign w_word = {w_err, f_pack(InmSrc, Hdr, Imm)};

  assign Instr  = r_mem[r_rd_ptr][27:0];
  assign OutErr = r_mem[r_rd_ptr][28];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IMM_ENC_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (ErrClr) begin
      r_err_cnt <= '0;
    end else if (w_push && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign ErrCount = r_err_cnt;
`else
  logic w_unused_clr;

  assign w_unused_clr = ErrClr;
  assign ErrCount     = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with an arithmetic reference queue model.
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        InValid;
  logic        InReady;
  logic [1:0]  InmSrc;
  logic [18:0] Imm;
  logic [11:0] Hdr;
  logic        OutValid;
  logic        OutReady;
  logic [27:0] Instr;
  logic        OutErr;
  logic        ErrClr;
  logic [7:0]  ErrCount;

  int total = 0;
  int bad   = 0;

  imm_encoder #(.DEPTH(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .InmSrc   (InmSrc),
    .Imm      (Imm),
    .Hdr      (Hdr),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Instr    (Instr),
    .OutErr   (OutErr),
    .ErrClr   (ErrClr),
    .ErrCount (ErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IMM_ENC_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: format selects immediate width n; header keeps its top 28-n bits.
  function automatic logic [28:0] model_word(input logic [1:0] f, input logic [11:0] h,
                                             input logic [18:0] im);
    int unsigned n;
    int unsigned lim;
    int unsigned ins;
    bit          e;
    n   = (f == 2'd2) ? 17 : (f == 2'd3) ? 16 : 19;
    lim = 32'd1 << n;
    ins = (32'(h) >> (n - 16)) * lim + (32'(im) % lim);
    e   = (f[1] == 1'b1) && (32'(im) >= lim);
    return {e, ins[27:0]};
  endfunction

  logic [28:0] q[$];
  int unsigned m_err = 0;
  int          dut_pops = 0;
  bit          m_push;
  bit          m_pop;
  logic [28:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_err = 0;
    end else begin
      m_push = InValid && (q.size() < 2);
      m_pop  = (q.size() > 0) && OutReady;
      m_word = model_word(InmSrc, Hdr, Imm);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(m_word);
      if (CNT_ON) begin
        if (ErrClr) m_err = 0;
        else if (m_push && m_word[28] && m_err < 255) m_err = m_err + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && OutValid && OutReady) dut_pops++;
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(InReady), 32'(q.size() != 2));
    chk("out_valid", 32'(OutValid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_instr", 32'(Instr), 32'(q[0][27:0]));
      chk("head_err", 32'(OutErr), 32'(q[0][28]));
    end
    chk("err_count", 32'(ErrCount), m_err);
  end

  task automatic set_in(input bit v, input logic [1:0] f, input logic [11:0] h,
                        input logic [18:0] im);
    InValid = v;
    InmSrc  = f;
    Hdr     = h;
    Imm     = im;
  endtask

  int base;

  initial begin
    rst_n    = 1'b0;
    OutReady = 1'b0;
    ErrClr   = 1'b0;
    set_in(1'b1, 2'd3, 12'h777, 19'h01111);

    // reset held with input traffic present
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(OutValid), 32'd0);
    chk("rst_in_ready", 32'(InReady), 32'd1);
    chk("rst_instr", 32'(Instr), 32'd0);
    chk("rst_err_count", 32'(ErrCount), 32'd0);
    #1 set_in(1'b0, 2'd0, 12'h0, 19'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", 32'(OutValid), 32'd0);

    // packing and range checks
    #1 OutReady = 1'b1;
    set_in(1'b1, 2'd3, 12'hABC, 19'h01234);
    @(negedge clk);
    chk("pack11_instr", 32'(Instr), 32'h0ABC1234);
    chk("pack11_err", 32'(OutErr), 32'd0);
    #1 set_in(1'b1, 2'd2, 12'hFFF, 19'h7FFFF);
    @(negedge clk);
    chk("rng10_instr", 32'(Instr), 32'h0FFFFFFF);
    chk("rng10_err", 32'(OutErr), 32'd1);
    chk("rng10_cnt", 32'(ErrCount), CNT_ON ? 32'd1 : 32'd0);
    #1 set_in(1'b1, 2'd1, 12'hFFF, 19'h7FFFF);
    @(negedge clk);
    chk("fmt01_instr", 32'(Instr), 32'h0FFFFFFF);
    chk("fmt01_err", 32'(OutErr), 32'd0);
    chk("fmt01_cnt", 32'(ErrCount), CNT_ON ? 32'd1 : 32'd0);
    #1 set_in(1'b0, 2'd0, 12'h0, 19'h0);
    repeat (2) @(negedge clk);

    // backpressure with A, B, C
    #1 OutReady = 1'b0;
    set_in(1'b1, 2'd3, 12'h111, 19'h0AAAA);
    @(negedge clk);
    #1 set_in(1'b1, 2'd2, 12'h222, 19'h15555);
    @(negedge clk);
    #1 set_in(1'b1, 2'd0, 12'h333, 19'h12345);
    @(negedge clk);
    chk("bp_full", 32'(InReady), 32'd0);
    chk("bp_head_a", 32'(Instr), 32'h0111AAAA);
    @(negedge clk);
    chk("bp_stall_a", 32'(Instr), 32'h0111AAAA);
    #1 OutReady = 1'b1;
    @(negedge clk);
    chk("bp_head_b", 32'(Instr), 32'h02235555);
    @(negedge clk);
    chk("bp_head_c", 32'(Instr), 32'h03312345);
    #1 set_in(1'b0, 2'd0, 12'h0, 19'h0);
    @(negedge clk);
    chk("bp_drained", 32'(OutValid), 32'd0);

    // continuous traffic at occupancy one
    base = dut_pops;
    for (int i = 0; i < 100; i++) begin
      #1 set_in(1'b1, 2'($urandom_range(0, 3)), 12'($urandom), 19'($urandom));
      @(negedge clk);
    end
    #1 set_in(1'b0, 2'd0, 12'h0, 19'h0);
    repeat (2) @(negedge clk);
    chk("stream_words", 32'(dut_pops - base), 32'd100);

    // counter saturation and clear priority
    for (int i = 0; i < 260; i++) begin
      #1 set_in(1'b1, 2'd3, 12'h5A5, 19'(32'h10000 + i));
      @(negedge clk);
    end
    #1 set_in(1'b0, 2'd0, 12'h0, 19'h0);
    @(negedge clk);
    chk("sat_cnt", 32'(ErrCount), CNT_ON ? 32'd255 : 32'd0);
    #1 ErrClr = 1'b1;
    set_in(1'b1, 2'd2, 12'h000, 19'h60000);
    @(negedge clk);
    chk("clr_cnt", 32'(ErrCount), 32'd0);
    chk("clr_word_err", 32'(OutErr), 32'd1);
    #1 ErrClr = 1'b0;
    set_in(1'b1, 2'd2, 12'h000, 19'h60000);
    @(negedge clk);
    chk("post_clr_cnt", 32'(ErrCount), CNT_ON ? 32'd1 : 32'd0);
    #1 set_in(1'b0, 2'd0, 12'h0, 19'h0);
    repeat (2) @(negedge clk);

    // mid-stream reset flushes buffered words
    #1 OutReady = 1'b0;
    set_in(1'b1, 2'd0, 12'h0F0, 19'h00042);
    @(negedge clk);
    #1 set_in(1'b1, 2'd2, 12'h0F0, 19'h60001);
    @(negedge clk);
    chk("pre_rst_full", 32'(InReady), 32'd0);
    #1 set_in(1'b0, 2'd0, 12'h0, 19'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(OutValid), 32'd0);
    chk("async_rst_ready", 32'(InReady), 32'd1);
    chk("async_rst_instr", 32'(Instr), 32'd0);
    chk("async_rst_cnt", 32'(ErrCount), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    OutReady = 1'b1;
    @(negedge clk);
    chk("after_rst_empty", 32'(OutValid), 32'd0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Packs a 19-bit immediate and its instruction header bits into the 28-bit instruction field for the selected immediate format (InmSrc 00/01 = 19-bit, 10 = 17-bit, 11 = 16-bit). It range-checks the immediate against that format. It sits on the program-load path between the instruction generator and the instruction-memory writer. It buffers words in a 2-entry FIFO with valid/ready handshakes on both sides and keeps a saturating count of range violations.

## Interface
- DEPTH, 2, FIFO entries (fixed at 2; other values unsupported)
- CNT_W, 8, width of ErrCount
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- InValid  in  1  input word valid
- InReady  out  1  FIFO can accept a word
- InmSrc  in  2  immediate format
- Imm  in  19  immediate value, unsigned
- Hdr  in  12  non-immediate bits, left-aligned (Hdr[11] maps to Instr[27])
- OutValid  out  1  FIFO head valid
- OutReady  in  1  consumer accepts head
- Instr  out  28  packed instruction field at FIFO head
- OutErr  out  1  head word had a range violation
- ErrClr  in  1  synchronous clear of ErrCount
- ErrCount  out  CNT_W  saturating range-violation count

## Operation
- Packing per format:
  - 00/01: Instr = {Hdr[11:3], Imm[18:0]}.
  - 10: Instr = {Hdr[11:1], Imm[16:0]}.
  - 11: Instr = {Hdr[11:0], Imm[15:0]}.
  - Unused low Hdr bits are ignored.
- Range check:
  - 10: error if Imm[18:17] != 0.
  - 11: error if Imm[18:16] != 0.
  - 00/01: never an error.
- An erroneous word is still enqueued, with its immediate truncated and OutErr=1. The consumer decides whether to drop it.
- Push happens when InValid && InReady. Pop happens when OutValid && OutReady.
- FIFO storage:
  - Two 29-bit entries ({err, instr}) with wr_ptr, rd_ptr (1 bit each) and count (0..2).
  - Pointers wrap 1 -> 0.
- InReady = (count != 2). A push is refused when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle with count = 1: count stays 1, both pointers advance.
- Push and pop in the same cycle with count = 0: not possible (OutValid = 0). The word is stored, and count becomes 1.
- OutValid = (count != 0). Instr and OutErr are driven from entry[rd_ptr] and must stay stable while OutValid && !OutReady.
- ErrCount:
  - Increments on each accepted push whose word has err = 1.
  - Saturates at 2^CNT_W − 1.
  - ErrClr has priority over an increment in the same cycle and forces 0.

## Timing
- Reset values (asynchronous on rst_n low):
  - count=0, wr_ptr=0, rd_ptr=0, ErrCount=0.
  - Hence OutValid=0, InReady=1, Instr=0, OutErr=0 (storage also cleared).
- Latency: a word accepted at edge N is visible at the head (OutValid=1) after edge N, provided the FIFO was empty.
- Throughput is one word per cycle when OutReady is held high.
- InReady and OutValid depend only on registered count. There are no combinational paths from input to output.
- A mid-stream reset discards all buffered words immediately. The first cycle after release is a clean empty state.
- ErrCount updates on the same edge as the accepting push.

## Configuration
- IMM_ENC_ERRCNT_EN:
  - Defined: the ErrCount register, saturation logic and ErrClr are built as specified.
  - Undefined: ErrCount is tied to 0 and ErrClr is ignored. Range checking and OutErr are unaffected.

## Test plan
- Reset: hold rst_n=0 while asserting InValid -> OutValid=0, InReady=1, ErrCount=0, and nothing is enqueued.
- Packing: push InmSrc=11, Hdr=12'hABC, Imm=19'h01234 with OutReady=1 -> next cycle Instr=28'hABC1234, OutErr=0.
- Range error: push InmSrc=10, Hdr=12'hFFF, Imm=19'h7FFFF -> Instr=28'hFFFFFFF (Imm truncated to 17'h1FFFF), OutErr=1, ErrCount=1. Push InmSrc=01 with the same Imm -> OutErr=0, ErrCount stays 1.
- Backpressure: OutReady=0 and push 3 words A, B, C back-to-back -> A and B accepted, InReady=0 on the third cycle, C held off. Then raise OutReady -> A, then B, then C delivered in order with Instr stable while stalled.
- Simultaneous push/pop at count=1 with continuous traffic of 100 words -> count stays 1, order is preserved, and no word is lost or duplicated.
- Saturation/clear (macro defined): 260 erroneous pushes -> ErrCount=255. Assert ErrClr together with an erroneous push -> ErrCount=0. With the macro undefined -> ErrCount stays 0 throughout.
